// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
//   Time-multiplexed driver for DIGITS common-anode 7-segment digits. It
//   hex-decodes nibbles or passes raw segment bytes through. It also handles
//   a decimal point per digit, leading-zero blanking and PWM brightness.
//   The display inputs are copied into a shadow register at frame start, so
//   one frame never shows a mix of old and new data.
//
//   Optional feature: define SEG7_BLINK_EN to add the i_blink port and the
//   BLINK_W parameter. A frame counter then blanks the flagged digits while
//   its MSB is 1.
//
// Ports
//   clk         system clock, rising edge
//   rstn        synchronous active-low reset
//   en          1: scan runs, 0: counters hold and the display is dark
//   disp_mode   0: hex (nibble k), 1: raw (byte k)
//   i_data      display data, 8*DIGITS bits
//   i_dp        decimal point per digit (hex mode only)
//   i_blank_lz  blank leading zero digits (hex mode only)
//   i_bright    PWM on-time, (i_bright+1)/2**BRIGHT_W of each slot
//   i_blink     (SEG7_BLINK_EN only) blink enable per digit
//   o_seg       segments, active-low, bit7 = dp, bit0 = a
//   o_sel       digit select, active-low, one-cold
//   o_frame     1-cycle pulse when the last digit slot ends
module seg7_scan_mux #(
  parameter int DIGITS   = 8,
  parameter int DIV_W    = 15,
  parameter int BRIGHT_W = 3
`ifdef SEG7_BLINK_EN
  , parameter int BLINK_W = 5
`endif
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  disp_mode,
  input  logic [8*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_blank_lz,
  input  logic [BRIGHT_W-1:0]   i_bright,
`ifdef SEG7_BLINK_EN
  input  logic [DIGITS-1:0]     i_blink,
`endif
  output logic [7:0]            o_seg,
  output logic [DIGITS-1:0]     o_sel,
  output logic                  o_frame
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    presc_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic                load_pend_reg;
  logic [8*DIGITS-1:0] sh_data_reg;
  logic [DIGITS-1:0]   sh_dp_reg;
  logic                sh_mode_reg;
  logic                sh_blank_reg;
`ifdef SEG7_BLINK_EN
  logic [DIGITS-1:0]   sh_blink_reg;
  logic [BLINK_W-1:0]  frame_cnt_reg;
`endif

  logic              tick;
  logic              frame_tick;
  logic              pwm_on;
  logic [7:0]        seg_sel;
  logic [DIGITS-1:0] sel_vec;
  logic [7:0]        digit_seg [DIGITS];
  logic [DIGITS-1:0] upper_nz;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  assign tick       = en && (presc_reg == '1);
  assign frame_tick = tick && (idx_reg == LAST_IDX);

  // The PWM phase is the top BRIGHT_W bits of the prescaler. i_bright is used
  // live, so brightness changes take effect within the current slot.
  assign pwm_on  = (presc_reg[DIV_W-1 -: BRIGHT_W] <= i_bright);
  assign sel_vec = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_reg);
  assign seg_sel = digit_seg[idx_reg];

  // Per-digit segment pattern, built from the shadow copy only.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [7:0] hex_seg;
      logic       lz_blank;
      logic [7:0] base_seg;

      // Flags whether any nibble from this digit up to the top digit is nonzero.
      assign upper_nz[gi] = |sh_data_reg[4*DIGITS-1 : 4*gi];
      assign hex_seg      = hex7(sh_data_reg[4*gi +: 4]) & {~sh_dp_reg[gi], 7'h7F};

      if (gi == 0) begin : g_first
        assign lz_blank = 1'b0;     // digit 0 always shows, so a value of 0 reads "0"
      end else begin : g_rest
        assign lz_blank = sh_blank_reg && !upper_nz[gi];
      end

      assign base_seg = sh_mode_reg ? sh_data_reg[8*gi +: 8]
                                    : (lz_blank ? 8'hFF : hex_seg);
`ifdef SEG7_BLINK_EN
      assign digit_seg[gi] = (sh_blink_reg[gi] && frame_cnt_reg[BLINK_W-1]) ? 8'hFF : base_seg;
`else
      assign digit_seg[gi] = base_seg;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc_reg     <= '0;
      idx_reg       <= '0;
      load_pend_reg <= 1'b1;
      sh_data_reg   <= '0;
      sh_dp_reg     <= '0;
      sh_mode_reg   <= 1'b0;
      sh_blank_reg  <= 1'b0;
      o_seg         <= 8'hFF;
      o_sel         <= '1;
      o_frame       <= 1'b0;
`ifdef SEG7_BLINK_EN
      sh_blink_reg  <= '0;
      frame_cnt_reg <= '0;
`endif
    end else begin
      if (en)
        presc_reg <= presc_reg + 1'b1;
      if (tick)
        idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
      o_frame <= frame_tick;

      // The shadow loads on the first cycle out of reset. After that it loads
      // on the same edge that moves the index back to digit 0.
      load_pend_reg <= 1'b0;
      if (load_pend_reg || frame_tick) begin
        sh_data_reg  <= i_data;
        sh_dp_reg    <= i_dp;
        sh_mode_reg  <= disp_mode;
        sh_blank_reg <= i_blank_lz;
`ifdef SEG7_BLINK_EN
        sh_blink_reg <= i_blink;
`endif
      end
`ifdef SEG7_BLINK_EN
      if (frame_tick)
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
`endif

      // Segments and select come from the same index on the same edge, so
      // they always change together and no digit shows another digit's pattern.
      if (en) begin
        o_seg <= seg_sel;
        o_sel <= pwm_on ? sel_vec : '1;
      end else begin
        o_seg <= 8'hFF;
        o_sel <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Testbench for seg7_scan_mux. It runs with DIGITS=8, DIV_W=4 and BRIGHT_W=2.
// A counting model derives every output from the number of enabled cycles
// since reset and from an input snapshot taken at each frame start. Directed
// frames are also checked against hand-computed segment patterns.
module tb_seg7_scan_mux;
  localparam int DIGITS   = 8;
  localparam int DIV_W    = 4;
  localparam int BRIGHT_W = 2;
  localparam int BLINK_W  = 2;
  localparam int SLOT     = 1 << DIV_W;
  localparam int FRAME    = SLOT * DIGITS;
  localparam logic [7:0] HEX_TBL [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic clk = 1'b0;
  logic rstn, en, disp_mode, i_blank_lz;
  logic [8*DIGITS-1:0] i_data;
  logic [DIGITS-1:0]   i_dp;
  logic [BRIGHT_W-1:0] i_bright;
  logic [DIGITS-1:0]   i_blink;
  logic [7:0]          o_seg;
  logic [DIGITS-1:0]   o_sel;
  logic                o_frame;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .DIGITS(DIGITS), .DIV_W(DIV_W), .BRIGHT_W(BRIGHT_W)
`ifdef SEG7_BLINK_EN
    , .BLINK_W(BLINK_W)
`endif
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .disp_mode(disp_mode), .i_data(i_data),
    .i_dp(i_dp), .i_blank_lz(i_blank_lz), .i_bright(i_bright),
`ifdef SEG7_BLINK_EN
    .i_blink(i_blink),
`endif
    .o_seg(o_seg), .o_sel(o_sel), .o_frame(o_frame)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int                  m_cnt;      // enabled cycles since reset release
  logic                m_pend;
  logic [8*DIGITS-1:0] s_data;
  logic [DIGITS-1:0]   s_dp, s_blink;
  logic                s_mode, s_blz;
  logic [7:0]          exp_seg;
  logic [DIGITS-1:0]   exp_sel;
  logic                exp_frame;
  logic                exp_valid = 1'b0;

  function automatic logic [7:0] model_seg(input int c);
    int k;
    logic [31:0] d;
    logic [7:0] s;
    k = (c / SLOT) % DIGITS;
    d = s_data[31:0];
    if (s_mode) s = s_data[8*k +: 8];
    else if (s_blz && k > 0 && (d >> (4*k)) == 0) s = 8'hFF;
    else begin
      s = HEX_TBL[4'((d >> (4*k)) & 32'hF)];
      if (s_dp[k]) s[7] = 1'b0;
    end
`ifdef SEG7_BLINK_EN
    if (s_blink[k] && (((c / FRAME) >> (BLINK_W-1)) & 1) == 1) s = 8'hFF;
`endif
    return s;
  endfunction

  function automatic logic [DIGITS-1:0] model_sel(input int c);
    int k, phase;
    logic [DIGITS-1:0] one;
    k     = (c / SLOT) % DIGITS;
    phase = (c % SLOT) >> (DIV_W - BRIGHT_W);
    one   = 1;
    return (phase <= int'(i_bright)) ? ~(one << k) : '1;
  endfunction

  always @(posedge clk) begin
    exp_valid <= 1'b1;
    if (!rstn) begin
      m_cnt <= 0; m_pend <= 1'b1;
      s_data <= '0; s_dp <= '0; s_blink <= '0; s_mode <= 1'b0; s_blz <= 1'b0;
      exp_seg <= 8'hFF; exp_sel <= '1; exp_frame <= 1'b0;
    end else begin
      exp_seg   <= en ? model_seg(m_cnt) : 8'hFF;
      exp_sel   <= en ? model_sel(m_cnt) : '1;
      exp_frame <= en && (m_cnt % FRAME == FRAME - 1);
      if (m_pend || (en && m_cnt % FRAME == FRAME - 1)) begin
        s_data <= i_data; s_dp <= i_dp; s_mode <= disp_mode; s_blz <= i_blank_lz; s_blink <= i_blink;
      end
      m_pend <= 1'b0;
      if (en) m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      check("model_seg", o_seg, exp_seg);
      check("model_sel", o_sel, exp_sel);
      check("model_frame", o_frame, exp_frame);
    end
  end

  // ---------------- directed stimulus ----------------
  logic [7:0] cap_seg [DIGITS];

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_frame && n < 3*FRAME);
    check("frame_timeout", o_frame, 1'b1);
  endtask

  // Call on the negedge where o_frame is high. Returns on the next such negedge.
  task automatic capture_frame(input int chg_k, input logic [63:0] chg_data);
    logic [7:0] sel_exp;
    for (int k = 0; k < DIGITS; k++) begin
      @(negedge clk);
      sel_exp = ~(8'h01 << k);
      check("sel_order", o_sel, sel_exp);
      cap_seg[k] = o_seg;
      if (k == chg_k) i_data = chg_data;
      repeat (SLOT - 1) @(negedge clk);
    end
    check("frame_period", o_frame, 1'b1);
  endtask

  task automatic check_frame(input string name, input logic [63:0] exp);
    for (int k = 0; k < DIGITS; k++) check(name, cap_seg[k], exp[8*k +: 8]);
  endtask

  task automatic count_on(input logic [BRIGHT_W-1:0] b, input int exp_on, input string name);
    int on = 0;
    i_bright = b;
    repeat (FRAME) begin
      @(negedge clk);
      if (o_sel != '1) on++;
    end
    check(name, on, exp_on);
  endtask

  initial begin
    logic [7:0] sel_before;
    rstn = 1'b0; en = 1'b0; disp_mode = 1'b0; i_blank_lz = 1'b0;
    i_data = '0; i_dp = '0; i_bright = 2'd3; i_blink = '0;
    repeat (3) @(negedge clk);
    check("reset_seg", o_seg, 8'hFF);
    check("reset_sel", o_sel, 8'hFF);
    check("reset_frame", o_frame, 1'b0);

    // hex scan
    i_data = 64'h89ABCDEF; en = 1'b1; rstn = 1'b1;
    wait_frame();
    capture_frame(-1, '0);
    check_frame("hex_89abcdef", 64'h8090_8883_C6A1_868E);

    // leading-zero blanking
    i_blank_lz = 1'b1; i_data = 64'h120;
    capture_frame(-1, '0);
    capture_frame(-1, '0);
    check_frame("blank_120", 64'hFFFF_FFFF_FFF9_A4C0);
    i_data = 64'h0;
    capture_frame(-1, '0);
    capture_frame(-1, '0);
    check_frame("blank_zero", 64'hFFFF_FFFF_FFFF_FFC0);

    // mid-frame data change
    i_blank_lz = 1'b0; i_data = 64'h89ABCDEF;
    capture_frame(-1, '0);
    capture_frame(3, 64'h01234567);
    check_frame("midframe_old", 64'h8090_8883_C6A1_868E);
    capture_frame(-1, '0);
    check_frame("midframe_new", 64'hC0F9_A4B0_9992_82F8);

    // brightness
    count_on(2'd0, 32, "bright0_on_cycles");
    count_on(2'd1, 64, "bright1_on_cycles");
    count_on(2'd3, 128, "bright3_on_cycles");

    // raw mode
    disp_mode = 1'b1; i_dp = 8'hFF; i_data = 64'h7879_7A7B_7C7D_7E7F;
    capture_frame(-1, '0);
    capture_frame(-1, '0);
    check_frame("raw_bytes", 64'h7879_7A7B_7C7D_7E7F);

    // pause with en=0 in the middle of digit 2
    repeat (40) @(negedge clk);
    sel_before = o_sel;
    check("pre_pause_sel", sel_before, 8'hFB);
    en = 1'b0;
    repeat (50) begin
      @(negedge clk);
      check("pause_sel", o_sel, 8'hFF);
      check("pause_seg", o_seg, 8'hFF);
    end
    en = 1'b1;
    @(negedge clk);
    check("resume_sel", o_sel, 8'hFB);
    check("resume_seg", o_seg, 8'h7D);

    // reset in the middle of a slot
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("midreset_seg", o_seg, 8'hFF);
    check("midreset_sel", o_sel, 8'hFF);
    check("midreset_frame", o_frame, 1'b0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("restart_sel", o_sel, 8'hFE);

`ifdef SEG7_BLINK_EN
    disp_mode = 1'b0; i_dp = '0; i_data = 64'h89ABCDEF; i_blink = 8'h01;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    for (int f = 0; f < 5; f++) begin
      check("blink_digit0", o_seg, (f == 2 || f == 3) ? 8'hFF : 8'h8E);
      repeat (FRAME) @(negedge clk);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end
endmodule
